// File: rtl/concat_arbiter.sv
// concat_arbiter
// Round-robin front end for the shared combinational Concatinator.
// One requester at a time is granted, its word is driven on conc_a, the
// Concatinator result is captured from conc_b one cycle later, and the
// result is returned with the requester id over a valid/ready port.
// A pending request is granted again on the same edge as an output handshake,
// so a continuously loaded arbiter moves one word every two cycles.

module concat_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 48,
  parameter int OUT_W   = 72,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [IN_W-1:0]         conc_a,
  input  logic [OUT_W-1:0]        conc_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        xfer_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_next;
  logic [ID_W-1:0] win_idx;
  logic            win_found;
  logic [IN_W-1:0] win_word;
  logic            handshake;
  logic            arb_window;
  logic            grant;

  // Requester index reached by stepping 'offset' places from 'base', wrapping
  // at NUM_REQ. Both operands are below NUM_REQ, so one subtraction suffices
  // even when NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] slot_of(input logic [ID_W-1:0] base,
                                              input int              offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return ID_W'(s);
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[slot_of(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = slot_of(rr_ptr, k);
      end
    end
  end

  // Word of the current winner and the pointer value that follows its grant.
  always_comb begin
    win_word = req_data[int'(win_idx)*IN_W +: IN_W];
    if (win_idx == ID_W'(NUM_REQ - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = win_idx + 1'b1;
    end
  end

  // A grant can happen from IDLE, or from HOLD on the same edge as the
  // output handshake so that a waiting request skips the IDLE cycle.
  always_comb begin
    handshake  = (state == HOLD) && out_ready;
    arb_window = (state == IDLE) || handshake;
    grant      = arb_window && win_found;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the busy flag.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next = CONV;
        end
      end
      CONV: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_next = win_found ? CONV : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant side: latch the winner's word and id, pulse its ack, advance rr_ptr.
  // conc_a only changes on a grant so the Concatinator input stays quiet
  // between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conc_a  <= '0;
      out_id  <= '0;
      req_ack <= '0;
      rr_ptr  <= '0;
    end else begin
      req_ack <= '0;
      if (grant) begin
        conc_a           <= win_word;
        out_id           <= win_idx;
        req_ack[win_idx] <= 1'b1;
        rr_ptr           <= rr_next;
      end
    end
  end

  // Result side: capture conc_b at the end of CONV and hold it until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == CONV) begin
        out_data  <= conc_b;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Completed-transfer counter, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (handshake) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule
